matmul_stream_ctrl: RTL and testbench

Sequencer for one systolic matrix-multiply pass. It accepts a start command, pulses an accumulator clear, and admits exactly `size` input rows back-to-back into the skew/array/deskew datapath. It tracks their fixed pipeline latency and flags each deskewed output row as valid. It sits between the row-source FIFO and the free-running systolic datapath, which has no clock enable.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/matmul_stream_ctrl_if.sv | 42 ++++
 rtl/valid_delay_line.sv | 26 ++
 rtl/matmul_stream_ctrl.sv | 104 ++++++++++
 tb/tb_matmul_stream_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the systolic matmul stream controller.
// Optional cycle counter in the top is guarded by MATMUL_CTRL_PERF_EN.
package matmul_pkg;

    localparam int data_size = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    // Skew plus deskew through a size x size array costs 2*size-1 cycles.
    function automatic int default_pipe_latency(input int size);
        return 2 * size - 1;
    endfunction

endpackage

// File: rtl/matmul_stream_ctrl_if.sv
// Handshake and status bundle between the row source, the controller and the datapath.
// The slave modport is the controller; the master side drives start/in_valid.
interface matmul_stream_ctrl_if;

    logic start;
    logic in_valid;
    logic in_ready;
    logic feed_en;
    logic clear_acc;
    logic out_valid;
    logic out_last;
    logic busy;
    logic done;
    logic underrun;

    modport slave (
        input  start,
        input  in_valid,
        output in_ready,
        output feed_en,
        output clear_acc,
        output out_valid,
        output out_last,
        output busy,
        output done,
        output underrun
    );

    modport master (
        output start,
        output in_valid,
        input  in_ready,
        input  feed_en,
        input  clear_acc,
        input  out_valid,
        input  out_last,
        input  busy,
        input  done,
        input  underrun
    );

endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register mirroring the datapath latency of a row.
module valid_delay_line #(
    parameter int depth = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [depth-1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < depth; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[depth-1];

endmodule

// File: rtl/matmul_stream_ctrl.sv
// Sequencer for one systolic matmul pass: clear, feed `size` rows, track latency, flag outputs.
// Define MATMUL_CTRL_PERF_EN to add the perf_cycles busy-cycle counter port.
module matmul_stream_ctrl
    import matmul_pkg::*;
#(
    parameter int size         = 3,
    parameter int pipe_latency = default_pipe_latency(size)
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef MATMUL_CTRL_PERF_EN
    output logic [31:0]          perf_cycles,
`endif
    matmul_stream_ctrl_if.slave  bus
);

    localparam int               cnt_w    = $clog2(size + 1);
    localparam logic [cnt_w-1:0] last_idx = cnt_w'(size - 1);

    state_t           state;
    state_t           state_next;
    logic [cnt_w-1:0] row_cnt;
    logic [cnt_w-1:0] out_cnt;
    logic             underrun_q;
    logic             feed;
    logic             delayed_valid;
    logic             last_row_out;

    assign feed         = bus.in_valid && (state == FEED);
    assign last_row_out = delayed_valid && (out_cnt == last_idx);

    // A gap before the first row is just waiting; a gap after it aborts the pass.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.start) state_next = CLEAR;
            CLEAR: state_next = FEED;
            FEED: begin
                if (bus.in_valid) begin
                    if (row_cnt == last_idx) state_next = DRAIN;
                end else if (row_cnt != '0) begin
                    state_next = IDLE;
                end
            end
            DRAIN: if (last_row_out) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row_cnt    <= '0;
            out_cnt    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state <= state_next;

            if (state == CLEAR)  row_cnt <= '0;
            else if (feed)       row_cnt <= row_cnt + 1'b1;

            if (state == CLEAR)     out_cnt <= '0;
            else if (delayed_valid) out_cnt <= out_cnt + 1'b1;

            if (state == IDLE && bus.start)
                underrun_q <= 1'b0;
            else if (state == FEED && !bus.in_valid && row_cnt != '0)
                underrun_q <= 1'b1;
        end
    end

    valid_delay_line #(
        .depth (pipe_latency)
    ) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .din   (feed),
        .dout  (delayed_valid)
    );

    assign bus.in_ready  = (state == FEED);
    assign bus.feed_en   = feed;
    assign bus.clear_acc = (state == CLEAR);
    assign bus.out_valid = delayed_valid;
    assign bus.out_last  = last_row_out;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.underrun  = underrun_q;

`ifdef MATMUL_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Restarts on an accepted start and freezes once the controller is idle again.
    always_ff @(posedge clk) begin
        if (reset)                           perf_q <= '0;
        else if (state == IDLE && bus.start) perf_q <= '0;
        else if (state != IDLE)              perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Self-checking bench for matmul_stream_ctrl: pass-level timeline model plus directed literal checks.
// Compile with MATMUL_CTRL_PERF_EN defined to also check perf_cycles.
module tb_matmul_stream_ctrl;
    import matmul_pkg::*;

    localparam int size    = 3;
    localparam int lat     = default_pipe_latency(size);
    localparam int max_cyc = 1024;
    localparam int far     = 1 << 30;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   checking = 1'b0;

    matmul_stream_ctrl_if bus();
`ifdef MATMUL_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    matmul_stream_ctrl #(
        .size         (size),
        .pipe_latency (lat)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef MATMUL_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle record of DUT outputs for the directed literal checks.
    bit log_busy [max_cyc];
    bit log_clear[max_cyc];
    bit log_feed [max_cyc];
    bit log_ov   [max_cyc];
    bit log_last [max_cyc];
    bit log_done [max_cyc];
    bit log_und  [max_cyc];
    bit log_rdy  [max_cyc];

    // Pass timeline model: start cycle, end cycle, rows taken, scheduled output rows.
    int m_start   = -1;
    int m_end     = 0;
    int m_rows    = 0;
    bit m_aborted = 1'b0;
    bit m_und     = 1'b0;
    int m_seen    = 0;
    int m_perf    = 0;
    int m_done_at = -1;
    bit m_sched[max_cyc + 64];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bit act, clr, inr, fe, ov, ol, dn;
        if (checking && cyc < max_cyc) begin
            act = (m_start >= 0) && (cyc > m_start) && (cyc <= m_end);
            clr = act && (cyc == m_start + 1);
            inr = act && (cyc >= m_start + 2) && (m_rows < size);
            fe  = inr && bus.in_valid;
            ov  = m_sched[cyc];
            ol  = ov && (m_seen == size - 1);
            dn  = act && (cyc == m_end) && !m_aborted;

            check_output("busy",      bus.busy,      act);
            check_output("clear_acc", bus.clear_acc, clr);
            check_output("in_ready",  bus.in_ready,  inr);
            check_output("feed_en",   bus.feed_en,   fe);
            check_output("out_valid", bus.out_valid, ov);
            check_output("out_last",  bus.out_last,  ol);
            check_output("done",      bus.done,      dn);
            check_output("underrun",  bus.underrun,  m_und);
`ifdef MATMUL_CTRL_PERF_EN
            check_output("perf_cycles", perf_cycles, m_perf);
`endif

            log_busy[cyc]  = bus.busy;
            log_clear[cyc] = bus.clear_acc;
            log_feed[cyc]  = bus.feed_en;
            log_ov[cyc]    = bus.out_valid;
            log_last[cyc]  = bus.out_last;
            log_done[cyc]  = bus.done;
            log_und[cyc]   = bus.underrun;
            log_rdy[cyc]   = bus.in_ready;

            if (reset) begin
                m_start = -1; m_end = 0; m_rows = 0; m_aborted = 1'b0;
                m_und = 1'b0; m_seen = 0; m_perf = 0;
                for (int i = cyc + 1; i < max_cyc + 64; i++) m_sched[i] = 1'b0;
            end else begin
                if (act) m_perf++;
                if (clr) m_seen = 0;
                else if (ov) m_seen++;
                if (inr) begin
                    if (bus.in_valid) begin
                        m_rows++;
                        m_sched[cyc + lat] = 1'b1;
                        if (m_rows == size) begin
                            m_end     = cyc + lat + 1;
                            m_done_at = m_end;
                        end
                    end else if (m_rows > 0) begin
                        m_und     = 1'b1;
                        m_aborted = 1'b1;
                        m_end     = cyc;
                    end
                end
                if (!act && bus.start) begin
                    m_start = cyc; m_end = far; m_rows = 0;
                    m_aborted = 1'b0; m_und = 1'b0; m_perf = 0;
                end
            end
        end
    end

    task automatic apply_stimulus_normal(output int s);
        s = cyc;
        bus.start = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (13) tick();
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int s, s2, n;
        reset = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0;
        tick();
        checking = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        check_output("idle_busy",  log_busy[cyc-1],  1'b0);
        check_output("idle_clear", log_clear[cyc-1], 1'b0);
        check_output("idle_ready", log_rdy[cyc-1],   1'b0);

        $display("[TB] normal pass, back-to-back rows");
        apply_stimulus_normal(s);
        check_output("a_clear1", log_clear[s+1], 1'b1);
        check_output("a_feed2",  log_feed[s+2],  1'b1);
        check_output("a_feed4",  log_feed[s+4],  1'b1);
        check_output("a_feed5",  log_feed[s+5],  1'b0);
        check_output("a_ov6",    log_ov[s+6],    1'b0);
        check_output("a_ov7",    log_ov[s+7],    1'b1);
        check_output("a_ov9",    log_ov[s+9],    1'b1);
        check_output("a_last8",  log_last[s+8],  1'b0);
        check_output("a_last9",  log_last[s+9],  1'b1);
        check_output("a_done10", log_done[s+10], 1'b1);
        check_output("a_busy10", log_busy[s+10], 1'b1);
        check_output("a_busy11", log_busy[s+11], 1'b0);
        check_output("a_model_done", m_done_at, s + 10);
`ifdef MATMUL_CTRL_PERF_EN
        check_output("a_perf", perf_cycles, 32'd10);
`endif

        $display("[TB] late first row");
        s = cyc;
        bus.start = 1'b1; bus.in_valid = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        check_output("b_feed4",  log_feed[s+4],  1'b0);
        check_output("b_feed5",  log_feed[s+5],  1'b1);
        check_output("b_feed7",  log_feed[s+7],  1'b1);
        check_output("b_und5",   log_und[s+5],   1'b0);
        check_output("b_done13", log_done[s+13], 1'b1);
        check_output("b_model_done", m_done_at, s + 13);

        $display("[TB] underrun after one row");
        s = cyc;
        bus.start = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.in_valid = 1'b0;
        repeat (12) tick();
        check_output("c_und3",  log_und[s+3],  1'b0);
        check_output("c_und4",  log_und[s+4],  1'b1);
        check_output("c_busy4", log_busy[s+4], 1'b0);
        check_output("c_ov7",   log_ov[s+7],   1'b1);
        n = 0;
        for (int i = s; i < s + 15; i++) n += int'(log_done[i]);
        check_output("c_no_done", n, 0);
        n = 0;
        for (int i = s; i < s + 15; i++) n += int'(log_ov[i]);
        check_output("c_ov_count", n, 1);
        apply_stimulus_normal(s2);
        check_output("c_und_held",    log_und[s2],    1'b1);
        check_output("c_und_cleared", log_und[s2+1],  1'b0);
        check_output("c_next_done",   log_done[s2+10], 1'b1);

        $display("[TB] reset mid-pass");
        s = cyc;
        bus.start = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        repeat (10) tick();
        check_output("d_busy7",  log_busy[s+7],  1'b0);
        check_output("d_rdy7",   log_rdy[s+7],   1'b0);
        check_output("d_und7",   log_und[s+7],   1'b0);
        n = 0;
        for (int i = s + 7; i < s + 17; i++) n += int'(log_ov[i]) + int'(log_done[i]);
        check_output("d_no_flight", n, 0);
        apply_stimulus_normal(s2);
        check_output("d_next_done", log_done[s2+10], 1'b1);

        $display("[TB] start pulses during FEED and DRAIN");
        s = cyc;
        bus.start = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        bus.start = 1'b0; repeat (2) tick();
        bus.start = 1'b1; repeat (2) tick();
        bus.start = 1'b0; repeat (9) tick();
        bus.in_valid = 1'b0;
        tick();
        n = 0;
        for (int i = s; i < s + 16; i++) n += int'(log_done[i]);
        check_output("e_one_done", n, 1);
        check_output("e_done10",   log_done[s+10], 1'b1);
        check_output("e_busy11",   log_busy[s+11], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
